// File: rtl/wb_stage_reg.sv
// Multi-lane MEM/WB pipeline register with stall/bubble/flush handling and a saturating retired-write counter.
// Optional forwarding query ports are compiled in when WB_STAGE_FWD_EN is defined.
module wb_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LANES   = 1,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES*DATA_W-1:0]   res_in,
    input  logic [LANES*ADDR_W-1:0]   rdest_in,
    input  logic [LANES-1:0]          we_in,
    output logic [LANES*DATA_W-1:0]   res_out,
    output logic [LANES*ADDR_W-1:0]   rdest_out,
    output logic [LANES-1:0]          we_out,
    output logic [LANES-1:0]          valid_out,
    output logic [CNT_W-1:0]          retired_cnt
`ifdef WB_STAGE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]         fwd_raddr0,
    input  logic [ADDR_W-1:0]         fwd_raddr1,
    output logic                      fwd_hit0,
    output logic                      fwd_hit1,
    output logic [DATA_W-1:0]         fwd_data0,
    output logic [DATA_W-1:0]         fwd_data1
`endif
);

    localparam int SUM_W = CNT_W + 3;

    logic                 stage_stall;
    logic                 next_stall;
    logic                 hold;
    logic                 clear;
    logic [LANES-1:0]     we_qual;
    logic [2:0]           pop;
    logic [SUM_W-1:0]     cnt_sum;
    logic [CNT_W-1:0]     cnt_next;
    logic                 stall_unused;

    assign stall_unused = ^stall;
    assign stage_stall  = stall[STAGE];
    assign next_stall   = stall[STAGE+1];
    assign hold         = stage_stall && next_stall && !flush;
    assign clear        = flush || (stage_stall && !next_stall);

    // Writes to x0 are architecturally discarded, so they never leave this stage enabled.
    always_comb begin
        we_qual = '0;
        for (int i = 0; i < LANES; i++) begin
            we_qual[i] = we_in[i] && (rdest_in[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + {2'b00, we_out[i]};
        end
        cnt_sum = {3'b000, retired_cnt} + {{CNT_W{1'b0}}, pop};
        if (cnt_sum > {3'b000, {CNT_W{1'b1}}}) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // The counter charges the entry currently held here, so a held entry is only charged when it finally leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_out     <= '0;
            rdest_out   <= '0;
            we_out      <= '0;
            valid_out   <= '0;
            retired_cnt <= '0;
        end else begin
            if (!hold) begin
                retired_cnt <= cnt_next;
            end
            if (clear) begin
                res_out   <= '0;
                rdest_out <= '0;
                we_out    <= '0;
                valid_out <= '0;
            end else if (!stage_stall) begin
                res_out   <= res_in;
                rdest_out <= rdest_in;
                we_out    <= we_qual;
                valid_out <= '1;
            end
        end
    end

`ifdef WB_STAGE_FWD_EN
    // Scanning upward lets the highest matching lane win, matching register-file write order.
    always_comb begin
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        for (int i = 0; i < LANES; i++) begin
            if (we_out[i] && (fwd_raddr0 != '0) && (rdest_out[i*ADDR_W +: ADDR_W] == fwd_raddr0)) begin
                fwd_hit0  = 1'b1;
                fwd_data0 = res_out[i*DATA_W +: DATA_W];
            end
            if (we_out[i] && (fwd_raddr1 != '0) && (rdest_out[i*ADDR_W +: ADDR_W] == fwd_raddr1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = res_out[i*DATA_W +: DATA_W];
            end
        end
    end
`endif

endmodule
